// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits, odd parity, stop, device ACK.
// Define PS2_TX_RETRY_EN to resend a failed frame up to twice before reporting an error.
module ps2_host_tx #(
   parameter int FILT_LEN    = 8,
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       rx_inhibit
);

   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int IW = $clog2(INHIBIT_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [FW-1:0] FILT_TOP = FW'(FILT_LEN - 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
   localparam logic [IW-1:0] INH_TOP  = IW'(INHIBIT_CYC);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_SHIFT,
      S_ACK,
      S_WAITHI
   } state_t;

   // Bit 0 carries the clock line, bit 1 the data line; idle bus level is high.
   logic [1:0] sync1_q, sync2_q;
   logic       clk_sync, dat_sync;

   logic          clk_filt_q, clk_filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          clk_fall;

   state_t        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic [9:0]    sh_q, sh_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [IW-1:0] inh_cnt_q, inh_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          clk_oe_q, clk_oe_d;
   logic          dat_oe_q, dat_oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          timeout;
   logic          fail;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]    retry_q, retry_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= {ps2_dat_i, ps2_clk_i};
         sync2_q <= sync1_q;
      end
   end

   assign clk_sync = sync2_q[0];
   assign dat_sync = sync2_q[1];

   // The filtered clock only follows the line after FILT_LEN consecutive cycles at the new level.
   always_comb begin
      clk_filt_d = clk_filt_q;
      filt_cnt_d = '0;
      if (clk_sync != clk_filt_q) begin
         if (filt_cnt_q == FILT_TOP) begin
            clk_filt_d = clk_sync;
         end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
         end
      end
   end

   assign clk_fall = clk_filt_q & ~clk_filt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_filt_q <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         clk_filt_q <= clk_filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      inh_cnt_d = inh_cnt_q;
      to_cnt_d  = to_cnt_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      timeout   = 1'b0;
      fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_d   = retry_q;
`endif

      // Device-paced window: from clock release until the ACK handshake completes.
      if (state_q == S_SHIFT || state_q == S_ACK || state_q == S_WAITHI) begin
         if (to_cnt_q == TO_LAST) begin
            timeout = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (tx_start && !busy_q) begin
               data_d    = tx_data;
               busy_d    = 1'b1;
               clk_oe_d  = 1'b1;
               dat_oe_d  = 1'b0;
               inh_cnt_d = '0;
               state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_d   = 2'd0;
`endif
            end
         end

         S_INHIBIT: begin
            if (inh_cnt_q == INH_TOP) begin
               // Start bit is already on the data line; releasing the clock hands control to the device.
               clk_oe_d  = 1'b0;
               to_cnt_d  = '0;
               bit_cnt_d = '0;
               sh_d      = {1'b1, ~^data_q, data_q};
               state_d   = S_SHIFT;
            end else begin
               inh_cnt_d = inh_cnt_q + IW'(1);
               if (inh_cnt_q == INH_LAST) begin
                  dat_oe_d = 1'b1;
               end
            end
         end

         S_SHIFT: begin
            if (timeout) begin
               fail = 1'b1;
            end else if (clk_fall) begin
               dat_oe_d = ~sh_q[0];
               sh_d     = {1'b1, sh_q[9:1]};
               if (bit_cnt_q == 4'd9) begin
                  state_d = S_ACK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end

         S_ACK: begin
            if (timeout) begin
               fail = 1'b1;
            end else if (clk_fall) begin
               if (dat_sync) begin
                  fail = 1'b1;
               end else begin
                  state_d = S_WAITHI;
               end
            end
         end

         S_WAITHI: begin
            if (timeout) begin
               fail = 1'b1;
            end else if (clk_filt_q && dat_sync) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
         end
      endcase

      if (fail) begin
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
         if (retry_q != 2'd2) begin
            retry_d   = retry_q + 2'd1;
            clk_oe_d  = 1'b1;
            inh_cnt_d = '0;
            state_d   = S_INHIBIT;
         end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
`else
         error_d = 1'b1;
         busy_d  = 1'b0;
         state_d = S_IDLE;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         sh_q      <= '0;
         bit_cnt_q <= '0;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         sh_q      <= sh_d;
         bit_cnt_q <= bit_cnt_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         clk_oe_q  <= clk_oe_d;
         dat_oe_q  <= dat_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign rx_inhibit = busy_q;

endmodule
